w_pattern_serializer: RTL and testbench
=======================================

# w_pattern_serializer

Upstream stimulus stage for the binary state machine. Captures a parallel bit pattern and shifts it out MSB-first on the 1-bit `w` line, one bit per bit-period, so the state machine receives a deterministic input sequence. Optional repeat mode replays the pattern continuously. Pass/abort status is reported back to the controlling logic.

## Interface
- `WIDTH`, 8: pattern register width in bits, ≥2.
- `TICK_DIV`, 1: clock cycles each bit is held on `w`, ≥1.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; all state cleared on the edge where it is sampled high.
- `load`  in  1  start request, sampled each edge.
- `pattern`  in  WIDTH  bits to send; `pattern[WIDTH-1]` goes first.
- `len`  in  $clog2(WIDTH+1)  number of bits to send from the MSB end.
- `rpt`  in  1  sampled with `load`; 1 = replay the pattern until aborted.
- `abort`  in  1  stop the transfer immediately.
- `w`  out  1  serial bit to the state machine (registered).
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse at the end of each completed pass.
- `bits_left`  out  $clog2(WIDTH+1)  bits remaining in the current pass, including the bit now on `w`.

## Operation
- States: IDLE, SHIFT.
- Registers: shift register `sr`, saved copy `pat_q`, saved length `len_q`, `rpt_q`, `bits_left`, tick counter `tcnt` (0..TICK_DIV-1).
- Reset values: `w`=0, `busy`=0, `done`=0, `bits_left`=0, `tcnt`=0, `sr`/`pat_q`/`len_q`/`rpt_q`=0, state IDLE.
- **IDLE → SHIFT.** Taken when `load`=1, `abort`=0, and the effective length is nonzero.
  - Effective length is `min(len, WIDTH)`.
  - On this edge: `sr` and `pat_q` ← `pattern`; `len_q` and `bits_left` ← effective length; `rpt_q` ← `rpt`; `w` ← `pattern[WIDTH-1]`; `busy` ← 1; `tcnt` ← 0.
- **Ignored requests.** `load` with effective length 0 is a no-op. `load` while in SHIFT is ignored; the pattern and length inputs are not re-sampled.
- **Bit advance in SHIFT.** When `tcnt`=TICK_DIV-1:
  - `tcnt` ← 0;
  - `sr` shifts left one place, filling with 0;
  - `w` ← the new MSB;
  - `bits_left` decrements.
  - Otherwise `tcnt` increments and `w` holds.
- **End of pass.** This is the advance at which `bits_left`=1.
  - `rpt_q`=0: go to IDLE; `w` ← 0; `busy` ← 0; `bits_left` ← 0; `done` ← 1 for exactly one cycle.
  - `rpt_q`=1: `sr` ← `pat_q`; `bits_left` ← `len_q`; `w` ← `pat_q[WIDTH-1]`; `done` pulses for one cycle; stay in SHIFT with no gap bit.
- **Abort.** `abort`=1 in SHIFT: go to IDLE on that edge; `w`=0, `busy`=0, `bits_left`=0; no `done` pulse. `abort` in IDLE is a no-op.
- **Priority:** `reset` > `abort` > end-of-pass > `load`.

## Timing
- Zero latency from request to first bit: the bit is on `w` in the cycle immediately after the edge that samples `load`. `busy` rises in that same cycle.
- Each bit is held on `w` for exactly TICK_DIV cycles.
- A non-repeat pass keeps `busy` high for exactly effective-length × TICK_DIV cycles.
- `done`=1 and `busy`=0 in the cycle right after the last bit period.
- A `load` sampled during that `done` cycle is accepted, giving back-to-back passes with no idle cycle between them.
- In repeat mode, `done` is high in the first cycle of every new pass, i.e. every len_q × TICK_DIV cycles.
- `reset` mid-transfer: all outputs at their reset values in the following cycle; no `done` pulse.

## Test plan
- **Reset values:** assert `reset` for 2 cycles with `load`=1 → `w`=0, `busy`=0, `done`=0, `bits_left`=0 throughout, and no transfer starts.
- **Basic pass (TICK_DIV=1):** `pattern`=8'b1011_0000, `len`=4, `rpt`=0 → `w` = 1,0,1,1 over 4 cycles with `bits_left` = 4,3,2,1. Next cycle: `done`=1, `busy`=0, `w`=0.
- **Bit hold (TICK_DIV=3):** `pattern`=8'b0100_0000, `len`=2 → `w`=0 for 3 cycles, then 1 for 3 cycles, then `done`.
- **Length boundaries and ignored loads:**
  - `len`=0 → no response.
  - `len`=12 → 8 bits are sent.
  - `load` with a new pattern mid-transfer → original pattern completes unchanged.
  - `load` during the `done` cycle → new pass starts with no gap.
- **Repeat and abort:** `pattern`=8'b1100_0000, `len`=3, `rpt`=1 → `w` = 1,1,0,1,1,0,… with `done` every 3 cycles. `abort` mid-pass → `w`=0 and `busy`=0 next cycle, with no `done`.
- **Reset mid-shift:** `reset` at bit 2 of 5 → all outputs return to reset values next cycle. A new `load` after reset sends from the MSB.

Source files
------------

// File: rtl/w_pattern_serializer.sv
// Parallel-to-serial stimulus source: shifts a captured pattern out MSB-first on w,
// holding each bit for TICK_DIV cycles, with optional continuous replay.
module w_pattern_serializer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned LW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic             rpt,
  input  logic             abort,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    bits_left
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic             rpt_q, rpt_d;
  logic [LW-1:0]    bits_left_q, bits_left_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             w_q, w_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LW-1:0]    eff_len;
  logic             tick_last;

  // Lengths beyond the register width are clamped rather than rejected.
  assign eff_len   = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
  assign tick_last = (tcnt_q == TW'(TICK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    pat_d       = pat_q;
    len_d       = len_q;
    rpt_d       = rpt_q;
    bits_left_d = bits_left_q;
    tcnt_d      = tcnt_q;
    w_d         = w_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load && !abort && (eff_len != '0)) begin
          state_d     = StShift;
          sr_d        = pattern;
          pat_d       = pattern;
          len_d       = eff_len;
          bits_left_d = eff_len;
          rpt_d       = rpt;
          w_d         = pattern[WIDTH-1];
          busy_d      = 1'b1;
          tcnt_d      = '0;
        end
      end
      StShift: begin
        if (abort) begin
          state_d     = StIdle;
          w_d         = 1'b0;
          busy_d      = 1'b0;
          bits_left_d = '0;
          tcnt_d      = '0;
        end else if (tick_last) begin
          tcnt_d = '0;
          if (bits_left_q == LW'(1)) begin
            done_d = 1'b1;
            if (rpt_q) begin
              // Replay starts in the very next bit period, no gap bit.
              sr_d        = pat_q;
              bits_left_d = len_q;
              w_d         = pat_q[WIDTH-1];
            end else begin
              state_d     = StIdle;
              sr_d        = {sr_q[WIDTH-2:0], 1'b0};
              w_d         = 1'b0;
              busy_d      = 1'b0;
              bits_left_d = '0;
            end
          end else begin
            sr_d        = {sr_q[WIDTH-2:0], 1'b0};
            w_d         = sr_q[WIDTH-2];
            bits_left_d = bits_left_q - LW'(1);
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      rpt_q       <= 1'b0;
      bits_left_q <= '0;
      tcnt_q      <= '0;
      w_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      rpt_q       <= rpt_d;
      bits_left_q <= bits_left_d;
      tcnt_q      <= tcnt_d;
      w_q         <= w_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign w         = w_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bits_left = bits_left_q;

endmodule

// File: tb/tb_w_pattern_serializer.sv
// Directed bench for w_pattern_serializer: one instance at TICK_DIV=1, one at TICK_DIV=3.
module tb_w_pattern_serializer;

  logic       clk = 1'b0;
  logic       reset, load1, load3, rpt, abort;
  logic [7:0] pattern;
  logic [3:0] len;

  logic       w1, busy1, done1;
  logic [3:0] bl1;
  logic       w3, busy3, done3;
  logic [3:0] bl3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  w_pattern_serializer #(.WIDTH(8), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .load(load1), .pattern(pattern), .len(len), .rpt(rpt),
    .abort(abort), .w(w1), .busy(busy1), .done(done1), .bits_left(bl1)
  );

  w_pattern_serializer #(.WIDTH(8), .TICK_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .load(load3), .pattern(pattern), .len(len), .rpt(rpt),
    .abort(abort), .w(w3), .busy(busy3), .done(done3), .bits_left(bl3)
  );

  // Advance one clock; outputs are observed 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load1 = 1'b1; load3 = 1'b1; pattern = 8'hFF; len = 4'd8;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({w1, busy1, done1, bl1} !== 7'b0) begin
        errors++;
        $display("FAIL reset_dut1 cyc%0d: got %b want 0000000", i, {w1, busy1, done1, bl1});
      end
      checks++;
      if ({w3, busy3, done3, bl3} !== 7'b0) begin
        errors++;
        $display("FAIL reset_dut3 cyc%0d: got %b want 0000000", i, {w3, busy3, done3, bl3});
      end
    end
    reset = 1'b0; load1 = 1'b0; load3 = 1'b0;
    step();
    checks++;
    if ({busy1, busy3} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_start: busy got %b want 00", {busy1, busy3});
    end
  endtask

  task automatic test_basic_pass();
    logic [6:0] exp [6] = '{7'b1100100, 7'b0100011, 7'b1100010, 7'b1100001,
                            7'b0010000, 7'b0000000};
    pattern = 8'b1011_0000; len = 4'd4; rpt = 1'b0; load1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      load1 = 1'b0;
      checks++;
      if ({w1, busy1, done1, bl1} !== exp[i]) begin
        errors++;
        $display("FAIL basic_pass cyc%0d: got %b want %b", i, {w1, busy1, done1, bl1}, exp[i]);
      end
    end
  endtask

  task automatic test_bit_hold();
    logic [6:0] exp [7] = '{7'b0100010, 7'b0100010, 7'b0100010, 7'b1100001,
                            7'b1100001, 7'b1100001, 7'b0010000};
    pattern = 8'b0100_0000; len = 4'd2; rpt = 1'b0; load3 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      load3 = 1'b0;
      checks++;
      if ({w3, busy3, done3, bl3} !== exp[i]) begin
        errors++;
        $display("FAIL bit_hold cyc%0d: got %b want %b", i, {w3, busy3, done3, bl3}, exp[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    pattern = 8'hFF; len = 4'd0; load1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({w1, busy1, done1, bl1} !== 7'b0) begin
        errors++;
        $display("FAIL len_zero cyc%0d: got %b want 0000000", i, {w1, busy1, done1, bl1});
      end
    end
    load1 = 1'b0;
  endtask

  task automatic test_len_clamp();
    logic [7:0] bits = 8'b1010_0101;
    pattern = bits; len = 4'd12; load1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      load1 = 1'b0;
      checks++;
      if ({w1, busy1, done1, bl1} !== {bits[7-i], 2'b10, 4'(8 - i)}) begin
        errors++;
        $display("FAIL len_clamp cyc%0d: got %b want %b", i, {w1, busy1, done1, bl1},
                 {bits[7-i], 2'b10, 4'(8 - i)});
      end
    end
    step();
    checks++;
    if ({w1, busy1, done1, bl1} !== 7'b0010000) begin
      errors++;
      $display("FAIL len_clamp_done: got %b want 0010000", {w1, busy1, done1, bl1});
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp [4] = '{7'b1100100, 7'b1100011, 7'b1100010, 7'b1100001};
    pattern = 8'hF0; len = 4'd4; load1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      // Re-request with a different pattern while shifting; must be ignored.
      load1 = (i == 0); pattern = 8'h0F; len = 4'd8;
      checks++;
      if ({w1, busy1, done1, bl1} !== exp[i]) begin
        errors++;
        $display("FAIL ignored_load cyc%0d: got %b want %b", i, {w1, busy1, done1, bl1}, exp[i]);
      end
    end
    step();
    checks++;
    if ({w1, busy1, done1, bl1} !== 7'b0010000) begin
      errors++;
      $display("FAIL ignored_load_done: got %b want 0010000", {w1, busy1, done1, bl1});
    end
    pattern = 8'h80; len = 4'd1; load1 = 1'b1;
    step();
    load1 = 1'b0;
    checks++;
    if ({w1, busy1, done1, bl1} !== 7'b1100001) begin
      errors++;
      $display("FAIL back_to_back_start: got %b want 1100001", {w1, busy1, done1, bl1});
    end
    step();
    checks++;
    if ({w1, busy1, done1, bl1} !== 7'b0010000) begin
      errors++;
      $display("FAIL back_to_back_done: got %b want 0010000", {w1, busy1, done1, bl1});
    end
  endtask

  task automatic test_repeat_abort();
    logic [6:0] exp [9] = '{7'b1100011, 7'b1100010, 7'b0100001,
                            7'b1110011, 7'b1100010, 7'b0100001,
                            7'b1110011, 7'b1100010, 7'b0100001};
    pattern = 8'b1100_0000; len = 4'd3; rpt = 1'b1; load1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      load1 = 1'b0;
      checks++;
      if ({w1, busy1, done1, bl1} !== exp[i]) begin
        errors++;
        $display("FAIL repeat cyc%0d: got %b want %b", i, {w1, busy1, done1, bl1}, exp[i]);
      end
    end
    // Abort on the end-of-pass edge: abort wins, so no done pulse.
    abort = 1'b1;
    step();
    abort = 1'b0; rpt = 1'b0;
    checks++;
    if ({w1, busy1, done1, bl1} !== 7'b0) begin
      errors++;
      $display("FAIL abort: got %b want 0000000", {w1, busy1, done1, bl1});
    end
    step();
    checks++;
    if ({w1, busy1, done1, bl1} !== 7'b0) begin
      errors++;
      $display("FAIL abort_stays_idle: got %b want 0000000", {w1, busy1, done1, bl1});
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [6:0] exp [4] = '{7'b0100011, 7'b1100010, 7'b1100001, 7'b0010000};
    pattern = 8'b1011_1000; len = 4'd5; load1 = 1'b1;
    step();
    load1 = 1'b0;
    step();
    checks++;
    if ({w1, busy1, done1, bl1} !== 7'b0100100) begin
      errors++;
      $display("FAIL pre_reset_bit2: got %b want 0100100", {w1, busy1, done1, bl1});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({w1, busy1, done1, bl1} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: got %b want 0000000", {w1, busy1, done1, bl1});
    end
    pattern = 8'b0110_0000; len = 4'd3; load1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      load1 = 1'b0;
      checks++;
      if ({w1, busy1, done1, bl1} !== exp[i]) begin
        errors++;
        $display("FAIL post_reset_load cyc%0d: got %b want %b", i, {w1, busy1, done1, bl1},
                 exp[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; load1 = 1'b0; load3 = 1'b0; rpt = 1'b0; abort = 1'b0;
    pattern = '0; len = '0;
    test_reset();
    test_basic_pass();
    test_bit_hold();
    test_len_zero();
    test_len_clamp();
    test_back_to_back();
    test_repeat_abort();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
